apb_slave_bank: RTL
===================

Name: apb_slave_bank

Overview:
Parametrised APB completer model. It replaces the fixed combinational slave stub that returned a constant read value.
- Provides NUM_SLAVES independent register banks, one per select bit.
- Supports programmable wait states via Pready and error signalling via Pslverr.
- Sits below the AHB-to-APB bridge and is the bridge's APB load in system benches.

Parameters:
NUM_SLAVES, 3, number of select lines and register banks (width of Pselx)
ADDR_W, 32, Paddr width
DATA_W, 32, Pwdata/Prdata width
REG_DEPTH, 16, words per bank; power of two, >=2
WAIT_CYCLES, 2, Pready-low cycles inserted in each ACCESS phase (0 = zero-wait)

Ports:
Hclk  in  1  single clock, all state on rising edge
Hresetn  in  1  asynchronous, active-low reset
Pselx  in  NUM_SLAVES  one-hot slave select
Penable  in  1  APB enable (ACCESS phase)
Pwrite  in  1  1=write, 0=read
Paddr  in  ADDR_W  byte address
Pwdata  in  DATA_W  write data
Pready  out  1  transfer-complete strobe, registered
Pslverr  out  1  error response, valid only while Pready=1, registered
Prdata  out  DATA_W  read data, valid while Pready=1 on reads, registered

Behaviour:
- Reset (Hresetn=0, async): Pready=0, Pslverr=0, Prdata=0, all bank words=0, FSM=IDLE, wait counter=0. Reset mid-transfer aborts the transfer; no write commits.
- Decode:
  - word index = Paddr[2+log2(REG_DEPTH)-1:2].
  - Error if any of: Paddr[1:0]!=0; Paddr bits above the index are nonzero; Pselx has more than one bit set.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE->SETUP when |Pselx & !Penable.
  - Penable=1 seen in IDLE is ignored; FSM stays IDLE and gives no response.
  - SETUP->ACCESS unconditionally on the next edge. Counter loads WAIT_CYCLES; Pselx/Paddr/Pwrite are latched at this edge.
  - ACCESS: while counter>0 it decrements each cycle and Pready stays 0.
  - ACCESS->IDLE on the edge after the Pready=1 cycle. If Pselx is nonzero with Penable=0 in that same cycle (back-to-back), go ->SETUP instead.
  - Pselx dropping to 0 during ACCESS before completion: abort to IDLE, no write, no Pready.
- Pready timing:
  - Pready is set on the edge where the counter reaches 0. With WAIT_CYCLES=0 it is set on the SETUP->ACCESS edge.
  - Result: Pready is high in ACCESS cycle number WAIT_CYCLES+1, for exactly one cycle, then cleared.
- Write commit:
  - On the edge where Penable=1 and Pready=1 and Pwrite=1 and no error: bank[sel][index] <= Pwdata.
  - On error, no bank changes.
- Read:
  - Prdata is loaded on the same edge that sets Pready, with bank[sel][index].
  - On error, or on a write, Prdata loads 0.
  - Prdata holds its value after Pready falls, until the next completion.
- Pslverr is set with Pready when the decode error holds, and cleared with Pready.
- Read-after-write to the same address in consecutive transfers returns the new data; no bypass is needed because transfers are at least 2 cycles apart.

Decomposition:
- Package apb_slave_pkg holds:
  - state enum {IDLE, SETUP, ACCESS};
  - localparam IDX_W = $clog2(REG_DEPTH);
  - function onehot_err(Pselx) returning 1 when zero bits or more than one bit are set.
- Sub-module apb_reg_bank: one REG_DEPTH x DATA_W bank with write-enable, write-index, write-data and async-read index. Instantiated NUM_SLAVES times via generate. The top holds the FSM, wait counter, decode and output registers.

Test Plan:
1. Reset then read slave0 addr 0x00, WAIT_CYCLES=2 -> Pready low for 2 ACCESS cycles, high in the 3rd; Prdata=0x0, Pslverr=0.
2. Write Pselx=3'b010, Paddr=0x08, Pwdata=0xA5A5_0001; then read the same -> read returns 0xA5A5_0001. Same address on slave0/slave2 still reads 0x0.
3. Read with Paddr=0x06 (misaligned), then Paddr=0x40 (out of range, REG_DEPTH=16), then Pselx=3'b011 -> each completes with Pready=1, Pslverr=1, Prdata=0. Writes with the same stimulus leave the banks unchanged.
4. WAIT_CYCLES=0 build: back-to-back write 0x1234_5678 to slave2 0x3C then read -> Pready high in the first ACCESS cycle of each; read returns 0x1234_5678.
5. Drop Pselx to 0 in the first ACCESS cycle of a write of 0xFFFF_FFFF to slave0 0x04 -> no Pready; a later read of slave0 0x04 returns 0x0.
6. Assert Hresetn=0 asynchronously mid-ACCESS after writing 0xDEAD_BEEF to slave1 0x00 -> Pready/Pslverr/Prdata go 0 immediately; post-reset read of slave1 0x00 returns 0x0.

Source files
------------

// File: rtl/apb_slave_pkg.sv
// Shared types and helpers for the APB completer bank: FSM encoding, default
// bank geometry and the select-line legality check.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int DEF_REG_DEPTH = 16;
  localparam int IDX_W         = $clog2(DEF_REG_DEPTH);
  localparam int MAX_SLAVES    = 32;

  // High when the select vector is not exactly one-hot (none or several set).
  function automatic logic onehot_err(input logic [MAX_SLAVES-1:0] sel);
    int n;
    n = 0;
    for (int i = 0; i < MAX_SLAVES; i++) begin
      if (sel[i]) n++;
    end
    return (n != 1);
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// One register bank: synchronous single-word write, asynchronous read, cleared
// by the asynchronous reset.
module apb_reg_bank #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [IW-1:0]     widx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IW-1:0]     ridx_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/apb_slave_bank.sv
// APB completer with NUM_SLAVES register banks, programmable wait states and
// decode-error response. All outputs are registered.
module apb_slave_bank
  import apb_slave_pkg::*;
#(
  parameter int NUM_SLAVES  = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int REG_DEPTH   = DEF_REG_DEPTH,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic [NUM_SLAVES-1:0] Pselx,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [ADDR_W-1:0]     Paddr,
  input  logic [DATA_W-1:0]     Pwdata,
  output logic                  Pready,
  output logic                  Pslverr,
  output logic [DATA_W-1:0]     Prdata,
  output state_t                dbg_state_o
);

  localparam int IW    = $clog2(REG_DEPTH);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  // Valid/ready contract: a transfer completes on the one cycle where the
  // master holds Penable=1 and this block drives Pready=1; Pslverr and Prdata
  // are meaningful only in that cycle (Prdata then holds until the next one).

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  write_q, write_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_W-1:0]     prdata_q, prdata_d;

  logic [NUM_SLAVES-1:0] dec_sel;
  logic [ADDR_W-1:0]     dec_addr;
  logic                  dec_write;
  logic [IW-1:0]         dec_idx;
  logic                  dec_err;
  logic                  load_rsp;
  logic                  commit;
  logic [DATA_W-1:0]     rd_mux;
  logic [DATA_W-1:0]     bank_rdata [NUM_SLAVES];

  // With zero wait states the response is built on the SETUP edge, before the
  // request has been latched, so decode looks at the live bus in SETUP.
  assign dec_sel   = (state_q == SETUP) ? Pselx  : sel_q;
  assign dec_addr  = (state_q == SETUP) ? Paddr  : addr_q;
  assign dec_write = (state_q == SETUP) ? Pwrite : write_q;
  assign dec_idx   = dec_addr[2 +: IW];
  assign dec_err   = (dec_addr[1:0] != 2'b00)
                   || ((dec_addr >> (2 + IW)) != '0)
                   || onehot_err(MAX_SLAVES'(dec_sel));

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dec_sel[i]) rd_mux = rd_mux | bank_rdata[i];
    end
  end

  assign commit = (state_q == ACCESS) && pready_q && Penable && write_q && !pslverr_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    write_d   = write_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    load_rsp  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|Pselx && !Penable) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = CNT_W'(WAIT_CYCLES);
        sel_d   = Pselx;
        addr_d  = Paddr;
        write_d = Pwrite;
        if (WAIT_CYCLES == 0) load_rsp = 1'b1;
      end
      ACCESS: begin
        if (pready_q) begin
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          cnt_d     = '0;
          state_d   = (|Pselx && !Penable) ? SETUP : IDLE;
        end else if (Pselx == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) load_rsp = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_rsp) begin
      pready_d  = 1'b1;
      pslverr_d = dec_err;
      prdata_d  = (dec_err || dec_write) ? '0 : rd_mux;
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_bank
    apb_reg_bank #(
      .DEPTH  (REG_DEPTH),
      .DATA_W (DATA_W)
    ) u_bank (
      .clk_i   (Hclk),
      .rst_ni  (Hresetn),
      .we_i    (commit && sel_q[g]),
      .widx_i  (addr_q[2 +: IW]),
      .wdata_i (Pwdata),
      .ridx_i  (dec_idx),
      .rdata_o (bank_rdata[g])
    );
  end

  assign Pready      = pready_q;
  assign Pslverr     = pslverr_q;
  assign Prdata      = prdata_q;
  assign dbg_state_o = state_q;

endmodule
